// File: rtl/ssm_hp_sequencer_if.sv
// ssm_hp_sequencer_if: tile stream from the sequencer to the SSM compute core.
// The sequencer drives valid and payload, and the core drives ready.
interface ssm_hp_sequencer_if #(
    parameter int DW     = 16,
    parameter int N_TILE = 16
);
    logic                 tile_valid_o;
    logic                 tile_ready_i;
    logic [DW-1:0]        dt_o;
    logic [DW-1:0]        dA_o;
    logic [DW-1:0]        x_o;
    logic [DW-1:0]        D_o;
    logic [N_TILE*DW-1:0] B_tile_o;
    logic [N_TILE*DW-1:0] C_tile_o;
    logic [N_TILE*DW-1:0] hprev_tile_o;

    modport master (
        output tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o, hprev_tile_o,
        input  tile_ready_i
    );

    modport slave (
        input  tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o, hprev_tile_o,
        output tile_ready_i
    );
endinterface

// File: rtl/ssm_hp_sequencer.sv
// ssm_hp_sequencer: scans (h, p, tile) for the SSM core, streams tile operands,
// tracks outstanding (h,p) groups in a tag FIFO and writes back y_final results.
// Optional performance counters are enabled by defining SSM_SEQ_PERF_CNT_EN.
module ssm_hp_sequencer #(
    parameter int DW        = 16,
    parameter int H         = 24,
    parameter int P         = 64,
    parameter int N_TOTAL   = 128,
    parameter int N_TILE    = 16,
    parameter int TAG_DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [$clog2(H)-1:0]       rd_h_o,
    output logic [$clog2(P)-1:0]       rd_p_o,
    output logic [$clog2(N_TOTAL)-1:0] rd_nbase_o,
    input  logic [DW-1:0]              dt_mem_i,
    input  logic [DW-1:0]              dA_mem_i,
    input  logic [DW-1:0]              D_mem_i,
    input  logic [DW-1:0]              x_mem_i,
    input  logic [N_TILE*DW-1:0]       B_mem_i,
    input  logic [N_TILE*DW-1:0]       C_mem_i,
    input  logic [N_TILE*DW-1:0]       hprev_mem_i,
    ssm_hp_sequencer_if.master         tile_if,
    input  logic [DW-1:0]              y_final_i,
    input  logic                       y_final_valid_i,
    output logic                       wr_en_o,
    output logic [$clog2(H*P)-1:0]     wr_addr_o,
    output logic [DW-1:0]              wr_data_o,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                tile_cnt_o
);
    localparam int TILES = N_TOTAL / N_TILE;
    localparam int HW    = $clog2(H);
    localparam int PBW   = $clog2(P);
    localparam int NBW   = $clog2(N_TOTAL);
    localparam int AW    = $clog2(H*P);
    localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int QW    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW    = $clog2(TAG_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [HW-1:0]  h_q;
    logic [PBW-1:0] p_q;
    logic [TW-1:0]  t_q;

    logic [AW-1:0]  tag_mem [TAG_DEPTH];
    logic [QW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  cnt_q;

    logic           wr_en_q;
    logic [AW-1:0]  wr_addr_q;
    logic [DW-1:0]  wr_data_q;
    logic           err_q;

    logic t_last, p_last, h_last, tag_blocked, accept, push, pop, start_acc;

    assign t_last      = (t_q == TW'(TILES - 1));
    assign p_last      = (p_q == PBW'(P - 1));
    assign h_last      = (h_q == HW'(H - 1));
    // A new group may only start once its tag has a free FIFO slot.
    assign tag_blocked = (t_q == '0) && (cnt_q == CW'(TAG_DEPTH));
    assign accept      = tile_if.tile_valid_o && tile_if.tile_ready_i;
    assign push        = accept && t_last;
    assign pop         = y_final_valid_i && (cnt_q != '0);
    assign start_acc   = (state_q == S_IDLE) && start_i;

    assign rd_h_o     = h_q;
    assign rd_p_o     = p_q;
    assign rd_nbase_o = NBW'(32'(t_q) * 32'(N_TILE));

    assign tile_if.dt_o         = dt_mem_i;
    assign tile_if.dA_o         = dA_mem_i;
    assign tile_if.x_o          = x_mem_i;
    assign tile_if.D_o          = D_mem_i;
    assign tile_if.B_tile_o     = B_mem_i;
    assign tile_if.C_tile_o     = C_mem_i;
    assign tile_if.hprev_tile_o = hprev_mem_i;

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign err_o     = err_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_ISSUE;
            S_ISSUE: if (accept && t_last && p_last && h_last) state_d = S_DRAIN;
            S_DRAIN: if ((cnt_q == '0) && !wr_en_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        tile_if.tile_valid_o = 1'b0;
        busy_o               = 1'b0;
        done_o               = 1'b0;
        unique case (state_q)
            S_ISSUE: begin
                tile_if.tile_valid_o = !tag_blocked;
                busy_o               = 1'b1;
            end
            S_DRAIN: busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Scan counters: tile innermost, then p, then h
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            h_q <= '0;
            p_q <= '0;
            t_q <= '0;
        end else if (accept) begin
            t_q <= t_last ? '0 : t_q + TW'(1);
            if (t_last) p_q <= p_last ? '0 : p_q + PBW'(1);
            if (t_last && p_last) h_q <= h_last ? '0 : h_q + HW'(1);
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= (wptr_q == QW'(TAG_DEPTH - 1)) ? '0 : wptr_q + QW'(1);
            if (pop)  rptr_q <= (rptr_q == QW'(TAG_DEPTH - 1)) ? '0 : rptr_q + QW'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

    // Tag FIFO storage: tag is the flat group address h*P+p
    always_ff @(posedge clk) begin
        if (push) tag_mem[wptr_q] <= AW'(32'(h_q) * 32'(P) + 32'(p_q));
    end

    // Writeback register, one cycle after the result pops its tag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= pop;
            if (pop) begin
                wr_addr_q <= tag_mem[rptr_q];
                wr_data_q <= y_final_i;
            end
        end
    end

    // Sticky flag for a result arriving with no outstanding tag
    always_ff @(posedge clk) begin
        if (rst)                                   err_q <= 1'b0;
        else if (y_final_valid_i && cnt_q == '0)   err_q <= 1'b1;
    end

`ifdef SSM_SEQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, tile_cnt_q;

    // Saturating stall / accepted-tile counters, cleared when a scan starts
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt_q <= '0;
            tile_cnt_q  <= '0;
        end else begin
            if (tile_if.tile_valid_o && !tile_if.tile_ready_i && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (accept && (tile_cnt_q != '1))
                tile_cnt_q <= tile_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign tile_cnt_o  = tile_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign tile_cnt_o  = '0;
`endif

endmodule
